microcode_sequencer: RTL
========================

# microcode_sequencer

Drives the CPU's microcode ROM. It fetches opcode bytes, forms the 9-bit ROM index from the byte plus a CB-prefix flag, and steps multi-cycle instructions through chained micro-op entries. It injects the interrupt-entry sequence at instruction boundaries and implements HALT. It sits between the bus/fetch unit and the microcode ROM, and its gated control word feeds the datapath.

## Interface
- INT_INDEX, 9'h120, ROM index of the first interrupt-entry micro-op
- CTRL_W, 64, control word width
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- fetch_req  out  1  request opcode byte at PC
- fetch_ready  in  1  fetch_data valid this cycle
- fetch_data  in  8  opcode byte
- pc_inc  out  1  one-cycle pulse: fetch accepted, increment PC
- uop_index  out  9  microcode ROM address (ROM is combinational)
- ctrl_word  in  CTRL_W  ROM output for uop_index
- ctrl_out  out  CTRL_W  ctrl_word when ctrl_valid, else all zero
- ctrl_valid  out  1  datapath may act on ctrl_out this cycle
- mem_busy  in  1  memory access in progress
- irq_pending  in  1  enabled interrupt requested (IE & IF non-zero)
- ime  in  1  interrupt master enable
- irq_ack  out  1  one-cycle pulse: interrupt entry started
- instr_done  out  1  one-cycle pulse: LAST step retired
- uop_step  out  4  step number within current instruction, saturates at 15

## Operation
- ctrl_word fields used: [63] LAST, [62] CBPFX, [61] WAIT, [60] HALT, [56:48] NEXT (next ROM index).
- States: IDLE, FETCH, EXEC, HALTED.
- IDLE: entered on reset. Goes to FETCH on the first clock edge after reset_n rises.
- FETCH: fetch_req=1. On fetch_ready, the next state is EXEC, uop_index <= {cb_flag, fetch_data}, pc_inc pulses in the same cycle, and uop_step <= 0.
- EXEC: ctrl_valid=1. The step is held when WAIT=1 and mem_busy=1: uop_index and uop_step are unchanged and ctrl_valid stays 1. Otherwise the step retires.
- Retire with LAST=0: uop_index <= NEXT; uop_step increments, saturating at 15.
- Retire with LAST=1: instr_done pulses. The next state is chosen by this priority:
  1. CBPFX → cb_flag <= 1, go to FETCH. No interrupt may split CB from its opcode.
  2. HALT and !irq_pending → HALTED.
  3. irq_pending & ime → EXEC at INT_INDEX, irq_ack pulses, uop_step <= 0.
  4. Otherwise → FETCH with cb_flag <= 0.
- cb_flag clears when an opcode is captured after a CB fetch. uop_index[8] therefore equals cb_flag at capture time.
- HALTED: ctrl_valid=0 and fetch_req=0. On irq_pending: if ime, go to interrupt entry as in rule 3; if !ime, go to FETCH. Neither path services the interrupt in the !ime case.

## Timing
- Reset values: state IDLE, uop_index 0, cb_flag 0, uop_step 0. All outputs are 0: fetch_req, pc_inc, ctrl_valid, ctrl_out, irq_ack, instr_done, uop_step.
- reset_n low at any time forces IDLE immediately. An in-flight fetch or micro-op is abandoned and no pulse is emitted.
- Fetch latency: from fetch_ready high, the first EXEC cycle is the next cycle.
- A single-step instruction (LAST=1, no WAIT stall) occupies exactly 1 EXEC cycle. An N-step instruction occupies N cycles plus stall cycles.
- Minimum instruction period with a zero-wait fetch: FETCH 1 cycle + EXEC N cycles.
- pc_inc, irq_ack and instr_done are registered or combinational single-cycle pulses and are never high for 2 consecutive cycles from the same event.
- The irq_pending and ime sample for boundary decisions happens in the LAST retire cycle only. Changes during the instruction are ignored.
- ctrl_out is combinational from ctrl_word, gated by ctrl_valid.

## Test plan
- Reset, then fetch_ready in the 1st FETCH cycle with fetch_data=0x00, ROM[0x000] LAST=1: expect uop_index=0x000, 1 ctrl_valid cycle, instr_done pulse, then fetch_req again.
- Fetch 0x01 with ROM chain 0x001→NEXT 0x150→NEXT 0x151 (LAST): expect uop_index 0x001, 0x150, 0x151 on consecutive cycles, uop_step 0,1,2, then instr_done.
- Fetch 0xCB (CBPFX, LAST), then 0x37 with irq_pending=1 and ime=1 throughout: expect uop_index 0x137 before any irq_ack; irq_ack and INT_INDEX only after 0x137's LAST.
- Step with WAIT=1 and mem_busy high for 3 cycles: expect uop_index held for 4 cycles and ctrl_valid=1 throughout, then advance.
- HALT executes with irq_pending=0: HALTED with ctrl_valid=0 and fetch_req=0. Raise irq_pending with ime=0: expect FETCH next with no irq_ack. Repeat with ime=1: expect irq_ack and uop_index=0x120.
- Assert reset_n low mid-chain at step 2: expect all outputs 0 immediately and a restart via IDLE→FETCH with cb_flag=0.

Source files
------------

// File: rtl/microcode_sequencer.sv
// Microcode sequencer: fetches opcodes, forms ROM indices, walks micro-op chains,
// injects interrupt entry at instruction boundaries and implements HALT.
module microcode_sequencer #(
  parameter logic [8:0]  INT_INDEX = 9'h120,
  parameter int unsigned CTRL_W    = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              fetch_req,
  input  logic              fetch_ready,
  input  logic [7:0]        fetch_data,
  output logic              pc_inc,
  output logic [8:0]        uop_index,
  input  logic [CTRL_W-1:0] ctrl_word,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic              ctrl_valid,
  input  logic              mem_busy,
  input  logic              irq_pending,
  input  logic              ime,
  output logic              irq_ack,
  output logic              instr_done,
  output logic [3:0]        uop_step
);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALTED} state_t;

  state_t     state, state_d;
  logic [8:0] index_d;
  logic [3:0] step_d;
  logic       cb_flag, cb_d;

  logic       f_last, f_cbpfx, f_wait, f_halt;
  logic [8:0] f_next;

  assign f_last  = ctrl_word[63];
  assign f_cbpfx = ctrl_word[62];
  assign f_wait  = ctrl_word[61];
  assign f_halt  = ctrl_word[60];
  assign f_next  = ctrl_word[56:48];

  assign ctrl_out = ctrl_valid ? ctrl_word : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      uop_index <= '0;
      uop_step  <= '0;
      cb_flag   <= 1'b0;
    end else begin
      state     <= state_d;
      uop_index <= index_d;
      uop_step  <= step_d;
      cb_flag   <= cb_d;
    end
  end

  always_comb begin
    state_d    = state;
    index_d    = uop_index;
    step_d     = uop_step;
    cb_d       = cb_flag;
    fetch_req  = 1'b0;
    pc_inc     = 1'b0;
    ctrl_valid = 1'b0;
    irq_ack    = 1'b0;
    instr_done = 1'b0;
    case (state)
      IDLE: state_d = FETCH;
      FETCH: begin
        fetch_req = 1'b1;
        if (fetch_ready) begin
          pc_inc  = 1'b1;
          state_d = EXEC;
          index_d = {cb_flag, fetch_data};
          step_d  = '0;
          cb_d    = 1'b0;
        end
      end
      EXEC: begin
        ctrl_valid = 1'b1;
        if (!(f_wait && mem_busy)) begin
          if (!f_last) begin
            index_d = f_next;
            if (uop_step != 4'hF) step_d = uop_step + 4'd1;
          end else begin
            instr_done = 1'b1;
            // A CB prefix must stay glued to its opcode, so it outranks HALT and interrupts.
            if (f_cbpfx) begin
              cb_d    = 1'b1;
              state_d = FETCH;
            end else if (f_halt && !irq_pending) begin
              state_d = HALTED;
            end else if (irq_pending && ime) begin
              irq_ack = 1'b1;
              state_d = EXEC;
              index_d = INT_INDEX;
              step_d  = '0;
            end else begin
              cb_d    = 1'b0;
              state_d = FETCH;
            end
          end
        end
      end
      HALTED: begin
        if (irq_pending) begin
          if (ime) begin
            irq_ack = 1'b1;
            state_d = EXEC;
            index_d = INT_INDEX;
            step_d  = '0;
          end else begin
            state_d = FETCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
